// File: rtl/pixel_write_queue.sv
// pixel_write_queue: clips pixel plots, maps (x,y) to linear addresses and drains them through a FIFO to the framebuffer
module pixel_write_queue #(
  parameter int H_RES   = 160,
  parameter int V_RES   = 120,
  parameter int DEPTH   = 16,
  parameter int COORD_W = 9,
  parameter int COLOR_W = 3,
  parameter int ADDR_W  = 15
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         write,
  input  logic [COORD_W-1:0]           x,
  input  logic [COORD_W-1:0]           y,
  input  logic [COLOR_W-1:0]           color,
  output logic                         in_ready,
  output logic                         fb_we,
  output logic [ADDR_W-1:0]            fb_addr,
  output logic [COLOR_W-1:0]           fb_color,
  input  logic                         fb_ready,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_level,
  output logic [7:0]                   clip_count,
  output logic                         idle
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);
  localparam int EW = ADDR_W + COLOR_W;
  typedef enum logic {EMPTY, FULL} state_t;
  state_t state;
  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic in_range, push, pop;
  logic [ADDR_W-1:0] addr;
  assign in_ready = fifo_level != LW'(DEPTH);
  assign in_range = x < COORD_W'(H_RES) && y < COORD_W'(V_RES);
  assign addr = ADDR_W'(y) * ADDR_W'(H_RES) + ADDR_W'(x);
  assign push = write && in_ready && in_range;
  // The output register refills whenever it is free or its current pixel completes this cycle
  assign pop = fifo_level != '0 && (state == EMPTY || fb_ready);
  assign idle = fifo_level == '0 && !fb_we;
  // FIFO storage; contents need no reset since pointers/level gate every read
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {addr, color};
  // Pointers, level, clip counter and the two-state output register
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= EMPTY;
      fb_we      <= 1'b0;
      fb_addr    <= '0;
      fb_color   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      clip_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      fifo_level <= fifo_level + LW'(push) - LW'(pop);
      if (write && in_ready && !in_range && clip_count != 8'hff) clip_count <= clip_count + 8'd1;
      if (pop) begin
        {fb_addr, fb_color} <= mem[rd_ptr];
        fb_we               <= 1'b1;
        state               <= FULL;
      end else if (fb_ready) begin
        fb_we <= 1'b0;
        state <= EMPTY;
      end
    end
  end
endmodule
